// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_pkg
//  Description : Shared constants and event type for the slide-switch input
//                path (debounce sampler and its consumers).
//  Revision    : 1.0  initial release
// ============================================================================
package sw_pkg;

    localparam int SW_WIDTH               = 8;
    localparam int DEBOUNCE_CYCLES_100MHZ = 1000000;   // 10 ms at 100 MHz
    localparam int SIM_DEBOUNCE_CYCLES    = 4;

    typedef struct packed {
        logic                change;
        logic [SW_WIDTH-1:0] changed;
        logic [SW_WIDTH-1:0] rise;
        logic [SW_WIDTH-1:0] fall;
    } sw_event_t;

endpackage : sw_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Parameterised-width two-flop synchroniser with synchronous
//                active-high reset; usable for switches and buttons alike.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/sw_debounce_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce_sampler
//  Description : Synchronises and whole-vector debounces the raw switch bus;
//                publishes the stable value plus one-cycle change/rise/fall
//                strobes. Optional macro SW_CHANGE_COUNT_EN adds change_count.
//  Revision    : 1.0  initial release
// ============================================================================
module sw_debounce_sampler
    import sw_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             change,
    output logic [WIDTH-1:0] changed_mask,
    output logic [WIDTH-1:0] rise_mask,
    output logic [WIDTH-1:0] fall_mask
`ifdef SW_CHANGE_COUNT_EN
   ,output logic [7:0]       change_count
`endif
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_acc = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] w_s2;
    logic [WIDTH-1:0] r_candidate;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_stable;
    logic             r_change;
    logic [WIDTH-1:0] r_changed;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             w_same;
    logic             w_accept;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_raw),
        .q   (w_s2)
    );

    // Accept only a candidate that differs from what is already published,
    // so a bounce that settles back to the old value stays silent.
    assign w_same   = (w_s2 == r_candidate);
    assign w_accept = w_same && (r_cnt == c_cnt_acc) && (r_candidate != r_stable);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_candidate <= '0;
            r_cnt       <= '0;
            r_stable    <= '0;
            r_change    <= 1'b0;
            r_changed   <= '0;
            r_rise      <= '0;
            r_fall      <= '0;
        end else begin
            if (!w_same) begin
                r_candidate <= w_s2;
                r_cnt       <= '0;
            end else if (r_cnt < c_cnt_max) begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_change <= w_accept;
            if (w_accept) begin
                r_stable  <= r_candidate;
                r_changed <= r_stable ^ r_candidate;
                r_rise    <= r_candidate & ~r_stable;
                r_fall    <= ~r_candidate & r_stable;
            end else begin
                r_changed <= '0;
                r_rise    <= '0;
                r_fall    <= '0;
            end
        end
    end

    assign sw_stable    = r_stable;
    assign change       = r_change;
    assign changed_mask = r_changed;
    assign rise_mask    = r_rise;
    assign fall_mask    = r_fall;

`ifdef SW_CHANGE_COUNT_EN
    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign change_count = r_count;
`endif

endmodule : sw_debounce_sampler
`default_nettype wire

// File: tb/tb_sw_debounce_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_debounce_sampler
//  Description : Scoreboard bench for sw_debounce_sampler with directed
//                switch sequences (STABLE_CYCLES = 4, pulse at edge +7).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sw_debounce_sampler;
    import sw_pkg::*;

    localparam int c_lat = SIM_DEBOUNCE_CYCLES + 3;

    typedef struct {
        int        edge_no;
        logic [7:0] stable;
        sw_event_t ev;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] sw_raw;
    logic [7:0] sw_stable;
    logic       change;
    logic [7:0] changed_mask;
    logic [7:0] rise_mask;
    logic [7:0] fall_mask;
`ifdef SW_CHANGE_COUNT_EN
    logic [7:0] change_count;
`endif

    int   n_vec  = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    exp_t q[$];

    sw_debounce_sampler #(
        .WIDTH         (SW_WIDTH),
        .STABLE_CYCLES (SIM_DEBOUNCE_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_raw       (sw_raw),
        .sw_stable    (sw_stable),
        .change       (change),
        .changed_mask (changed_mask),
        .rise_mask    (rise_mask),
        .fall_mask    (fall_mask)
`ifdef SW_CHANGE_COUNT_EN
       ,.change_count (change_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a new raw value right after an edge, queue the expected pulse.
    task automatic step_expect(input logic [7:0] v, input logic [7:0] st,
                               input logic [7:0] ch, input logic [7:0] ri,
                               input logic [7:0] fa, input int hold);
        exp_t e;
        sw_raw     = v;
        e.edge_no  = edge_cnt + c_lat;
        e.stable   = st;
        e.ev.change  = 1'b1;
        e.ev.changed = ch;
        e.ev.rise    = ri;
        e.ev.fall    = fa;
        q.push_back(e);
        tick(hold);
    endtask

    // Monitor: pop an expectation on every change pulse; masks must be idle otherwise.
    always begin
        @(posedge clk);
        #1;
        if (change) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_edge",   edge_cnt,     e.edge_no);
                chk("pulse_stable", sw_stable,    e.stable);
                chk("changed_mask", changed_mask, e.ev.changed);
                chk("rise_mask",    rise_mask,    e.ev.rise);
                chk("fall_mask",    fall_mask,    e.ev.fall);
            end
        end else if (!rst) begin
            chk("idle_masks", {changed_mask, rise_mask, fall_mask}, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        sw_raw = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("reset_stable", sw_stable, 0);
            chk("reset_change", change, 0);
`ifdef SW_CHANGE_COUNT_EN
            chk("reset_count", change_count, 0);
`endif
        end
        rst = 1'b0;
        q.push_back('{edge_no: edge_cnt + c_lat, stable: 8'hFF,
                      ev: '{change: 1'b1, changed: 8'hFF, rise: 8'hFF, fall: 8'h00}});
        tick(10);

        step_expect(8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 10);
        step_expect(8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 10);
        step_expect(8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 10);

        // Bounce: only the final settled 0x0B is accepted.
        sw_raw = 8'h03; tick(2);
        sw_raw = 8'h00; tick(1);
        sw_raw = 8'h03; tick(1);
        step_expect(8'h0B, 8'h0B, 8'h0B, 8'h0B, 8'h00, 12);

        step_expect(8'h81, 8'h81, 8'h8A, 8'h80, 8'h0A, 12);

        // Return-to-same produces no pulse.
        sw_raw = 8'h80; tick(3);
        sw_raw = 8'h81; tick(15);
        chk("return_same_stable", sw_stable, 8'h81);
`ifdef SW_CHANGE_COUNT_EN
        chk("count_after_6", change_count, 6);
`endif

        // Reset mid-debounce discards the pending 0x00 candidate.
        sw_raw = 8'h00; tick(3);
        rst = 1'b1;     tick(2);
        chk("midreset_stable", sw_stable, 0);
`ifdef SW_CHANGE_COUNT_EN
        chk("midreset_count", change_count, 0);
`endif
        rst = 1'b0;     tick(12);
        chk("post_reset_stable", sw_stable, 0);

        // 257 alternating accepted changes.
        for (int i = 0; i < 257; i++) begin
            if (i % 2 == 0) step_expect(8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 9);
            else            step_expect(8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 9);
        end
        tick(4);
        chk("loop_stable", sw_stable, 8'h01);
`ifdef SW_CHANGE_COUNT_EN
        chk("count_wrap", change_count, 1);
        rst = 1'b1; tick(1);
        chk("count_reset", change_count, 0);
        rst = 1'b0; tick(1);
        // Reset cleared sw_stable while raw is 0x01: it is re-accepted.
        q.push_back('{edge_no: edge_cnt - 1 + c_lat, stable: 8'h01,
                      ev: '{change: 1'b1, changed: 8'h01, rise: 8'h01, fall: 8'h00}});
        tick(10);
        chk("count_after_reaccept", change_count, 1);
`endif
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_sw_debounce_sampler
`default_nettype wire

// File: doc/sw_debounce_sampler.md
Name: sw_debounce_sampler

Overview:
- Input-side counterpart of the switch/LED datapath. Takes the raw, asynchronous 8-bit slide-switch bus, synchronises it and debounces it as a whole vector.
- Publishes a stable switch value plus one-cycle change strobes: changed, rising and falling bit masks.
- Sits between the board `sw` pins and the combinational `sw`→`led` logic in `Top`. That logic consumes `sw_stable` instead of the raw pins.

Parameters:
- WIDTH, 8: number of switch bits.
- STABLE_CYCLES, 1000000: consecutive clock cycles the synchronised vector must hold before acceptance. At 100 MHz this is 10 ms. Legal range is ≥1.
- CNT_W, $clog2(STABLE_CYCLES+1): stability counter width. Derived; not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sw_raw  in  WIDTH  raw switch pins, asynchronous to clk.
- sw_stable  out  WIDTH  debounced switch value.
- change  out  1  one-cycle pulse when sw_stable updates.
- changed_mask  out  WIDTH  old^new; valid only while change=1, otherwise 0.
- rise_mask  out  WIDTH  new&~old; valid only while change=1, otherwise 0.
- fall_mask  out  WIDTH  ~new&old; valid only while change=1, otherwise 0.
- change_count  out  8  accepted-change counter. Present only with SW_CHANGE_COUNT_EN.

Behaviour:
- Synchronous, active-high reset on rst. All registers are cleared on the reset edge:
  - sync stages, candidate and cnt = 0;
  - sw_stable = 0;
  - change = 0; all masks = 0;
  - change_count = 0.
- Reset mid-debounce discards the pending candidate. After rst deasserts, a non-zero input is re-accepted through the full latency and produces a change pulse.
- Synchroniser: two-flop chain, sw_raw→s1→s2, all WIDTH bits in parallel.
- Stability tracker, evaluated each edge:
  - If s2 != candidate: candidate<=s2, cnt<=0.
  - Else if cnt < STABLE_CYCLES: cnt<=cnt+1. cnt saturates at STABLE_CYCLES and never wraps.
- Accept condition: s2==candidate && cnt==STABLE_CYCLES-1 && candidate!=sw_stable. At that edge:
  - sw_stable<=candidate;
  - change<=1;
  - masks are computed from the old and new values.
  On every other edge, change and all masks <= 0.
- Latency: a raw change held steady updates sw_stable and asserts change at the (STABLE_CYCLES+3)th rising edge after the change. That is 2 edges of sync, 1 to load candidate, then STABLE_CYCLES.
- Glitch rejection: any bounce that alters s2 before acceptance restarts the count. No partial acceptance of individual bits; the whole vector is debounced as one.
- Return-to-same: if the input bounces and settles back to the current sw_stable, the accept condition is false. No pulse; sw_stable is unchanged.
- Multi-bit change: if several bits settle in the same window, there is one pulse, and changed_mask shows all of them.
- Saturated cnt holds with no further pulses until s2 changes again.
- No combinational path from sw_raw to any output.

Optional Feature:
- Macro: SW_CHANGE_COUNT_EN.
- Defined: the change_count port exists. It increments by 1 on each accepted change, in the same edge as the change pulse, and wraps 255→0. rst clears it.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package sw_pkg holds:
  - SW_WIDTH=8;
  - DEBOUNCE_CYCLES_100MHZ=1000000;
  - SIM_DEBOUNCE_CYCLES=4;
  - sw_event_t, a struct of change, changed, rise and fall masks.
- One natural sub-module, sync_2ff: parameterised-width two-flop synchroniser with synchronous reset. It is reusable for button inputs.

Test Plan (STABLE_CYCLES=4 for all):
- Reset: rst=1 for 3 cycles with sw_raw=8'hFF, then release → sw_stable=0 during reset. After release, change pulses once at edge 7, with sw_stable=8'hFF and rise_mask=8'hFF.
- Clean step: sw_raw 8'h00→8'h01 held → at edge 7, change=1 for exactly 1 cycle, sw_stable=8'h01, changed_mask=rise_mask=8'h01, fall_mask=0.
- Bounce: 8'h00→8'h03 for 2 cycles →8'h00 for 1 →8'h03 for 1 →8'h0B held → exactly one change pulse, with sw_stable=8'h0B. No pulse for 8'h03.
- Multi-bit/fall: from stable 8'h0B apply 8'h81 → one pulse:
  - changed_mask=8'h8A;
  - rise_mask=8'h80;
  - fall_mask=8'h0A.
- Return-to-same: stable 8'h81, raw 8'h80 for 3 cycles then back to 8'h81 → no pulse; sw_stable stays 8'h81.
- SW_CHANGE_COUNT_EN defined: drive 257 distinct accepted changes → change_count=8'h01. Assert mid-sequence → change_count=0.
